// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state encoding and default widths.
package sdram_pkg;

  localparam int unsigned DQ_W   = 16;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned BA_W   = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] NOP       = 4'b0111;
  localparam logic [3:0] ACTIVE    = 4'b0011;
  localparam logic [3:0] READ      = 4'b0101;
  localparam logic [3:0] WRITE     = 4'b0100;
  localparam logic [3:0] B_TERM    = 4'b0110;
  localparam logic [3:0] PRECHARGE = 4'b0010;
  localparam logic [3:0] AREF      = 4'b0001;
  localparam logic [3:0] LOAD_MODE = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

  typedef enum logic {
    LG_WRITE = 1'b0,
    LG_READ  = 1'b1
  } last_grant_t;

endpackage

// File: rtl/sdram_arbit.sv
// Grants the SDRAM pins to one of init / refresh / write / read engines and
// owns the DQ tristate.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned DQ_W   = sdram_pkg::DQ_W,
  parameter int unsigned ADDR_W = sdram_pkg::ADDR_W,
  parameter int unsigned BA_W   = sdram_pkg::BA_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              wr_sdram_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DQ_W-1:0]   sdram_data_out,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  arb_state_t  state;
  last_grant_t last_grant;
  logic [3:0]  cmd;

  // Enables are set on entry and cleared on the same edge that returns to ARBIT,
  // so an engine never sees its grant still high once its burst has ended.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_INIT;
      last_grant <= LG_READ;
      aref_en    <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (init_end) state <= ST_ARBIT;
        end
        ST_ARBIT: begin
          if (aref_req) begin
            state   <= ST_AREF;
            aref_en <= 1'b1;
          end else if (wr_req && (!rd_req || last_grant == LG_READ)) begin
            state      <= ST_WRITE;
            wr_en      <= 1'b1;
            last_grant <= LG_WRITE;
          end else if (rd_req) begin
            state      <= ST_READ;
            rd_en      <= 1'b1;
            last_grant <= LG_READ;
          end
        end
        ST_AREF: begin
          if (aref_end) begin
            state   <= ST_ARBIT;
            aref_en <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (wr_end) begin
            state <= ST_ARBIT;
            wr_en <= 1'b0;
          end
        end
        ST_READ: begin
          if (rd_end) begin
            state <= ST_ARBIT;
            rd_en <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    cmd        = NOP;
    sdram_ba   = '1;
    sdram_addr = '1;
    unique case (state)
      ST_INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd        = NOP;
        sdram_ba   = '1;
        sdram_addr = '1;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;

  assign sdram_dq       = (state == ST_WRITE && wr_sdram_en) ? wr_data : 'z;
  assign sdram_data_out = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed self-checking bench for sdram_arbit: init handoff, grants,
// round-robin, refresh priority, DQ tristate and mid-burst reset.
module tb_sdram_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [12:0] init_addr;
  logic        aref_req, aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;
  logic        wr_req, wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_sdram_en;
  logic        rd_req, rd_end;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr;
  logic        aref_en, wr_en, rd_en;
  logic [15:0] sdram_data_out;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  wire  [15:0] sdram_dq;

  logic        tb_drv;
  logic [15:0] tb_dq;
  assign sdram_dq = tb_drv ? tb_dq : 'z;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_arbit #(.DQ_W(16), .ADDR_W(13), .BA_W(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
    .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_sdram_en(wr_sdram_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_data_out(sdram_data_out), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq(sdram_dq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic check_pins(input string tag, input logic [3:0] cmd,
                            input logic [1:0] ba, input logic [12:0] addr);
    check({tag, "_cmd"}, {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, cmd});
    check({tag, "_ba"}, {30'd0, sdram_ba}, {30'd0, ba});
    check({tag, "_addr"}, {19'd0, sdram_addr}, {19'd0, addr});
  endtask

  // en = {aref_en, wr_en, rd_en}
  task automatic check_en(input string tag, input logic [2:0] en);
    check(tag, {29'd0, aref_en, wr_en, rd_en}, {29'd0, en});
  endtask

  task automatic pulse_end(input int unsigned which);
    case (which)
      0: aref_end = 1'b1;
      1: wr_end   = 1'b1;
      default: rd_end = 1'b1;
    endcase
    tick();
    aref_end = 1'b0;
    wr_end   = 1'b0;
    rd_end   = 1'b0;
  endtask

  initial begin
    sys_rst  = 1'b1;
    init_end = 1'b0; init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400;
    aref_req = 1'b0; aref_end = 1'b0; aref_cmd = 4'b0001; aref_ba = 2'b00; aref_addr = 13'h0000;
    wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'h0abc;
    wr_data = 16'hA5A5; wr_sdram_en = 1'b0;
    rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'b11; rd_addr = 13'h0123;
    tb_drv = 1'b0; tb_dq = 16'h3C3C;

    tick(); tick();
    check_en("rst_en", 3'b000);
    check("rst_cke", {31'd0, sdram_cke}, 32'd1);
    check_pins("rst_pins", 4'b0010, 2'b01, 13'h0400);
    sys_rst = 1'b0;

    // Init phase: pins follow the init engine until init_end is seen
    for (int i = 1; i < 20; i++) tick();
    check_pins("init_c19", 4'b0010, 2'b01, 13'h0400);
    init_end = 1'b1;
    tick();
    check_pins("arbit_nop", 4'b0111, 2'b11, 13'h1fff);
    check_en("arbit_en", 3'b000);

    // Lone read request
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check_en("rd_grant", 3'b001);
    check_pins("rd_pins", 4'b0101, 2'b11, 13'h0123);
    tb_drv = 1'b1;
    tick();
    check("rd_dq_in", {16'd0, sdram_data_out}, {16'd0, 16'h3C3C});
    for (int i = 2; i < 12; i++) tick();
    check_en("rd_hold", 3'b001);
    pulse_end(2);
    check_en("rd_release", 3'b000);
    check_pins("rd_back_nop", 4'b0111, 2'b11, 13'h1fff);

    // All three requests: refresh first
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    aref_req = 1'b0;
    check_en("all_aref", 3'b100);
    check_pins("aref_pins", 4'b0001, 2'b00, 13'h0000);
    wr_end = 1'b1;  // end pulse for another engine must be ignored
    tick();
    wr_end = 1'b0;
    check_en("aref_ign_wr_end", 3'b100);
    pulse_end(0);
    check_en("aref_gap", 3'b000);
    tick();
    check_en("all_write", 3'b010);
    check_pins("wr_pins", 4'b0100, 2'b10, 13'h0abc);
    tb_drv = 1'b0; wr_sdram_en = 1'b1;
    #1;
    check("wr_dq", {16'd0, sdram_dq}, {16'd0, 16'hA5A5});
    tick();
    wr_sdram_en = 1'b0;
    pulse_end(1);
    check_en("wr_gap", 3'b000);
    tick();
    check_en("all_read", 3'b001);

    // Both held: strict alternation with one ARBIT cycle between grants
    for (int i = 0; i < 4; i++) begin
      pulse_end((i % 2 == 0) ? 2 : 1);
      check_en($sformatf("rr_gap%0d", i), 3'b000);
      tick();
      check_en($sformatf("rr_grant%0d", i), (i % 2 == 0) ? 3'b010 : 3'b001);
    end

    // Refresh request during a read waits for the burst to finish
    wr_req = 1'b0; rd_req = 1'b0;
    aref_req = 1'b1;
    tick(); tick();
    check_en("aref_wait", 3'b001);
    pulse_end(2);
    check_en("aref_mid_gap", 3'b000);
    tick();
    check_en("aref_after_rd", 3'b100);
    aref_req = 1'b0;
    pulse_end(0);

    // Reset in the middle of a write burst
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check_en("wr2_grant", 3'b010);
    wr_sdram_en = 1'b1;
    #1;
    check("wr2_dq", {16'd0, sdram_dq}, {16'd0, 16'hA5A5});
    #1;
    sys_rst = 1'b1;
    tb_drv  = 1'b1;
    #1;
    check_en("mid_rst_en", 3'b000);
    check_pins("mid_rst_init", 4'b0010, 2'b01, 13'h0400);
    check("mid_rst_dq_released", {16'd0, sdram_data_out}, {16'd0, 16'h3C3C});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
